router_sync_n: RTL and testbench

// - Parametrised successor of the 3-port router synchroniser: sits between the router FSM/register
//   and NUM_PORTS output FIFOs. Latches the destination address from the header byte, steers the
//   FSM write strobe to one FIFO, reports the selected FIFO's full flag and drives per-port vld_out.
// - New vs. 3-port version: any port count, configurable soft-reset timeout, invalid-address detection.

---
 rtl/router_pkg.sv | 15 +
 rtl/router_sync_timer.sv | 37 +++
 rtl/router_sync_n.sv | 70 +++++++
 tb/tb_router_sync_n.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: port limit, default soft-reset timeout and a
// constant-foldable clog2 used for counter sizing.
package router_pkg;

  localparam int ROUTER_MAX_PORTS   = 8;
  localparam int ROUTER_TIMEOUT_DEF = 30;

  function automatic int router_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port idle-valid watchdog: pulses soft_reset for one cycle after
// TIMEOUT consecutive cycles of valid data that nobody reads.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int CNT_W = router_clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // A read on the would-be-timeout edge takes priority over the pulse.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser for NUM_PORTS output FIFOs: header address latch,
// write-strobe steering, full-flag mux, valid outputs and per-port timeouts.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int TIMEOUT   = ROUTER_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic                 write_enb_reg,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sel;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      addr_q   <= '0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      addr_q   <= addr_in;
      addr_err <= (int'(addr_in) >= NUM_PORTS);
    end
  end

  // Bypass the latch during DECODE so the FSM sees the full flag immediately;
  // an out-of-range address reads as not-full so the bad packet drains.
  assign sel = detect_add ? addr_in : addr_q;

  always_comb begin
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == ADDR_W'(i)) fifo_full = full[i];
    end
  end

  always_comb begin
    write_enb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      write_enb[i] = write_enb_reg & ~addr_err & (addr_q == ADDR_W'(i));
    end
  end

  assign vld_out = ~fifo_empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .vld        (vld_out[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: a 3-port/TIMEOUT=30 instance and a
// 5-port/TIMEOUT=4 instance sharing clock and reset.
module tb_router_sync_n;

  logic clk;
  logic resetn;

  logic       detect_add_a, write_enb_reg_a;
  logic [1:0] addr_in_a;
  logic [2:0] read_enb_a, fifo_empty_a, full_a;
  logic [2:0] vld_out_a, write_enb_a, soft_reset_a;
  logic       fifo_full_a, addr_err_a;

  logic       detect_add_b, write_enb_reg_b;
  logic [2:0] addr_in_b;
  logic [4:0] read_enb_b, fifo_empty_b, full_b;
  logic [4:0] vld_out_b, write_enb_b, soft_reset_b;
  logic       fifo_full_b, addr_err_b;

  int passed;
  int total;

  router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30)) dut_a (
    .clk(clk), .resetn(resetn), .detect_add(detect_add_a), .write_enb_reg(write_enb_reg_a),
    .addr_in(addr_in_a), .read_enb(read_enb_a), .fifo_empty(fifo_empty_a), .full(full_a),
    .vld_out(vld_out_a), .write_enb(write_enb_a), .fifo_full(fifo_full_a),
    .soft_reset(soft_reset_a), .addr_err(addr_err_a)
  );

  router_sync_n #(.NUM_PORTS(5), .ADDR_W(3), .TIMEOUT(4)) dut_b (
    .clk(clk), .resetn(resetn), .detect_add(detect_add_b), .write_enb_reg(write_enb_reg_b),
    .addr_in(addr_in_b), .read_enb(read_enb_b), .fifo_empty(fifo_empty_b), .full(full_b),
    .vld_out(vld_out_b), .write_enb(write_enb_b), .fifo_full(fifo_full_b),
    .soft_reset(soft_reset_b), .addr_err(addr_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    resetn = 1'b1;
    detect_add_a = 1'b0; write_enb_reg_a = 1'b0; addr_in_a = '0;
    read_enb_a = '0; fifo_empty_a = 3'b111; full_a = '0;
    detect_add_b = 1'b0; write_enb_reg_b = 1'b0; addr_in_b = '0;
    read_enb_b = '0; fifo_empty_b = 5'b11111; full_b = '0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("rst_soft_reset_a", 32'(soft_reset_a), 32'h0);
    check("rst_addr_err_a", 32'(addr_err_a), 32'h0);
    check("rst_write_enb_a", 32'(write_enb_a), 32'h0);
    check("rst_vld_out_a", 32'(vld_out_a), 32'h0);
    check("rst_soft_reset_b", 32'(soft_reset_b), 32'h0);

    // Header to port 2 with full[2] visible in the decode cycle
    detect_add_a = 1'b1; addr_in_a = 2'd2; full_a = 3'b100;
    #1;
    check("decode_bypass_full", 32'(fifo_full_a), 32'h1);
    tick();
    detect_add_a = 1'b0; write_enb_reg_a = 1'b1; full_a = 3'b011;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("payload_write_enb_p2", 32'(write_enb_a), 32'h4);
      check("payload_fifo_full_p2", 32'(fifo_full_a), 32'h0);
      tick();
    end
    write_enb_reg_a = 1'b0;

    // Invalid address 3: drained, never stalls
    detect_add_a = 1'b1; addr_in_a = 2'd3; full_a = 3'b111;
    #1;
    check("bad_addr_decode_full", 32'(fifo_full_a), 32'h0);
    tick();
    detect_add_a = 1'b0;
    #1;
    check("bad_addr_err", 32'(addr_err_a), 32'h1);
    write_enb_reg_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bad_write_enb", 32'(write_enb_a), 32'h0);
      check("bad_fifo_full", 32'(fifo_full_a), 32'h0);
      tick();
    end
    write_enb_reg_a = 1'b0; full_a = 3'b000;
    detect_add_a = 1'b1; addr_in_a = 2'd1;
    tick();
    detect_add_a = 1'b0;
    #1;
    check("good_addr_err_clear", 32'(addr_err_a), 32'h0);
    write_enb_reg_a = 1'b1;
    #1;
    check("good_write_enb_p1", 32'(write_enb_a), 32'h2);
    tick();
    write_enb_reg_a = 1'b0;

    fifo_empty_a = 3'b010;
    #1;
    check("vld_out_map", 32'(vld_out_a), 32'h5);
    fifo_empty_a = 3'b111;
    #1;

    // Port 1 valid and unread: pulses at edge 30 and 60
    fifo_empty_a = 3'b101;
    for (int cyc = 1; cyc <= 61; cyc++) begin
      tick();
      check($sformatf("timeout_c%0d", cyc), 32'(soft_reset_a),
            (cyc == 30 || cyc == 60) ? 32'h2 : 32'h0);
    end
    fifo_empty_a = 3'b111;
    tick();

    // Read on the would-be-timeout edge cancels the pulse and restarts the count
    fifo_empty_a = 3'b101;
    for (int cyc = 1; cyc <= 61; cyc++) begin
      read_enb_a = (cyc == 30) ? 3'b010 : 3'b000;
      tick();
      check($sformatf("rd_cancel_c%0d", cyc), 32'(soft_reset_a),
            (cyc == 60) ? 32'h2 : 32'h0);
    end
    read_enb_a = 3'b000;
    fifo_empty_a = 3'b111;

    // Latch a bad address on A so reset has something to clear
    detect_add_a = 1'b1; addr_in_a = 2'd3;
    tick();
    detect_add_a = 1'b0;

    // Ports 0 and 4 of B idle-valid together
    fifo_empty_b = 5'b01110;
    #1;
    check("vld_out_b", 32'(vld_out_b), 32'h11);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      check($sformatf("multi_c%0d", cyc), 32'(soft_reset_b),
            (cyc % 4 == 0) ? 32'h11 : 32'h0);
    end

    // Asynchronous reset mid-run
    full_a = 3'b001;
    #1;
    check("pre_rst_addr_err", 32'(addr_err_a), 32'h1);
    check("pre_rst_fifo_full", 32'(fifo_full_a), 32'h0);
    resetn = 1'b1;
    #1;
    check("async_rst_addr_err", 32'(addr_err_a), 32'h0);
    check("async_rst_soft_reset_b", 32'(soft_reset_b), 32'h0);
    check("async_rst_write_enb", 32'(write_enb_a), 32'h0);
    check("async_rst_addr_q", 32'(fifo_full_a), 32'h1);
    tick();
    resetn = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
